uart_in: RTL

- UART receiver: deserialises 8N1 frames into bytes. Frame format: idle-high line, start bit 0, 8 data bits LSB first, stop bit 1.
- Companion receive path to the team's uart_out transmitter. Sits between the external RX pin and the byte-consumer logic.
- Oversamples the line at CLKS_PER_BIT clocks per bit and samples each bit at its middle.
- Reports a good byte or a framing error with a one-cycle pulse.

---
 rtl/uart_in_if.sv | 25 ++
 rtl/uart_in.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_in_if.sv
// Receive-side bundle for uart_in: serial RX line in, received byte and status pulses out.
// master drives the line (pin model / upstream), slave is the receiver itself.
interface uart_in_if;
  logic       in;
  logic [7:0] data;
  logic       flag_ready;
  logic       flag_error;
  logic       flag_busy;

  modport master (
    output in,
    input  data,
    input  flag_ready,
    input  flag_error,
    input  flag_busy
  );

  modport slave (
    input  in,
    output data,
    output flag_ready,
    output flag_error,
    output flag_busy
  );
endinterface

// File: rtl/uart_in.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit validation at mid-bit,
// mid-bit data sampling and a one-cycle ready/error pulse per frame.
module uart_in #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_in_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          s1, s2;
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!s2) begin
          state_d = START;
        end
      end

      // A start bit that is high again at its midpoint is treated as a glitch.
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          if (s2) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
          end
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          shift_d   = {s2, shift_q[7:1]};
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end
        end
      end

      // Re-arm at mid-stop-bit so back-to-back frames are not missed.
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          if (s2) begin
            data_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.flag_ready = ready_q;
  assign bus.flag_error = error_q;
  assign bus.flag_busy  = (state_q != IDLE);

endmodule
